// File: rtl/mem_read_arbiter_pkg.sv
// Shared AXI constants, FSM state type and small helpers for the
// two-requester read arbiter.
package mem_read_arbiter_pkg;

    // AXI encodings driven or checked by the arbiter.
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [2:0] SIZE_16B   = 3'b100;

    // Bursts are issued 16-byte aligned, matching SIZE_16B beats.
    localparam int ALIGN_BITS = 4;

    // Top-level controller states: one burst in flight at most.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_e;

    // One-hot strobe for the requester that owns the current burst.
    function automatic logic [1:0] owner_onehot(input logic owner);
        return owner ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: a lone request always wins; under contention
// the requester that was not granted last time wins.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // Pick the winner from the current requests and the last winner.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Arbitrates two burst-read requesters onto a single AXI read port.
// One burst is outstanding at a time; R beats are forwarded to the owner
// combinationally and a burst error is reported with the final beat.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              resetn,
    // requester side
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [3:0]        req_len0,
    input  logic [3:0]        req_len1,
    // AXI AR channel
    output logic [ADDR_W-1:0] araddr,
    output logic [1:0]        arburst,
    output logic [3:0]        arlen,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    // AXI R channel
    input  logic [DATA_W-1:0] rdata,
    input  logic              rvalid,
    input  logic              rlast,
    input  logic [1:0]        rresp,
    output logic              rready,
    // response side
    output logic [DATA_W-1:0] resp_data,
    output logic [1:0]        resp_valid,
    output logic              resp_last,
    output logic              resp_err,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-ALIGN_BITS){1'b1}}, {ALIGN_BITS{1'b0}}};

    state_e            state_q,      state_d;
    logic [ADDR_W-1:0] addr_q,       addr_d;
    logic [3:0]        len_q,        len_d;
    logic              owner_q,      owner_d;
    logic              last_grant_q, last_grant_d;
    logic [3:0]        beat_cnt_q,   beat_cnt_d;
    logic              err_q,        err_d;

    logic [1:0]        grant;
    logic              beat_err;

    rr_arbiter2 u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Constant AR attributes and the aligned, latched burst address.
    assign araddr    = addr_q & ALIGN_MASK;
    assign arlen     = len_q;
    assign arburst   = BURST_INCR;
    assign arsize    = SIZE_16B;
    assign resp_data = rdata;
    assign busy      = (state_q != IDLE);

    // A beat is bad if the slave flags it, or if it closes the burst at the wrong count.
    assign beat_err = (rresp != RESP_OKAY) || (rlast && (beat_cnt_q != len_q));

    // Next-state and output decode for the IDLE -> ADDR -> DATA controller.
    always_comb begin
        // NOTE: every output and next-state value is defaulted first, so no branch can leave one unassigned and infer a latch.
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        req_ready    = 2'b00;
        arvalid      = 1'b0;
        rready       = 1'b0;
        resp_valid   = 2'b00;
        resp_last    = 1'b0;
        resp_err     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Held off while reset is asserted so req_ready stays low.
                if (resetn && (grant != 2'b00)) begin
                    req_ready    = grant;
                    owner_d      = grant[1];
                    last_grant_d = grant[1];
                    addr_d       = grant[1] ? req_addr1 : req_addr0;
                    len_d        = grant[1] ? req_len1  : req_len0;
                    beat_cnt_d   = 4'd0;
                    err_d        = 1'b0;
                    state_d      = ADDR;
                end
            end

            ADDR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                rready = 1'b1;
                if (rvalid) begin
                    resp_valid = owner_onehot(owner_q);
                    resp_last  = rlast;
                    if (rlast) begin
                        resp_err   = err_q | beat_err;
                        beat_cnt_d = 4'd0;
                        err_d      = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        // Reaching len without rlast means the slave overran the burst.
                        beat_cnt_d = beat_cnt_q + 4'd1;
                        if (beat_err || (beat_cnt_q == len_q)) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            len_q        <= 4'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_cnt_q   <= 4'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: a transaction-level model of the
// outstanding burst is compared with the DUT every cycle, with directed
// scenarios carrying literal expectations followed by randomized traffic.
module tb_mem_read_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              resetn;
    logic [1:0]        req_valid, req_ready;
    logic [ADDR_W-1:0] req_addr0, req_addr1;
    logic [3:0]        req_len0, req_len1;
    logic [ADDR_W-1:0] araddr;
    logic [1:0]        arburst;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic              arvalid, arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid, rlast;
    logic [1:0]        rresp;
    logic              rready;
    logic [DATA_W-1:0] resp_data;
    logic [1:0]        resp_valid;
    logic              resp_last, resp_err, busy;

    mem_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_len0   (req_len0),
        .req_len1   (req_len1),
        .araddr     (araddr),
        .arburst    (arburst),
        .arlen      (arlen),
        .arsize     (arsize),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .rlast      (rlast),
        .rresp      (rresp),
        .rready     (rready),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .resp_last  (resp_last),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one outstanding burst described by whether its
    // address has been accepted, how many beats were seen and whether
    // anything went wrong. m_next is the requester that wins a tie.
    // ------------------------------------------------------------------
    bit          m_busy    = 1'b0;
    bit          m_ar_done = 1'b0;
    bit          m_owner   = 1'b0;
    bit          m_next    = 1'b0;
    bit          m_err     = 1'b0;
    logic [31:0] m_addr    = '0;
    int          m_len     = 0;
    int          m_cnt     = 0;

    // Compare outputs against the model mid-cycle, then advance the model
    // with the inputs the next rising edge will see.
    always @(negedge clk) begin
        logic [1:0] g;
        bit         beat;
        bit         bad_beat;
        g = 2'b00;
        if (!m_busy && resetn === 1'b1) begin
            g = (req_valid == 2'b11) ? (m_next ? 2'b10 : 2'b01) : req_valid;
        end
        beat     = m_busy && m_ar_done && rvalid;
        bad_beat = (rresp != 2'b00) || (rlast && (m_cnt != m_len));

        check("req_ready", req_ready, g);
        check("busy", busy, m_busy);
        check("arvalid", arvalid, m_busy && !m_ar_done);
        if (m_busy && !m_ar_done) begin
            check("araddr", araddr, m_addr & 32'hFFFF_FFF0);
            check("arlen", arlen, m_len);
            check("arburst", arburst, 2'b01);
            check("arsize", arsize, 3'b100);
        end
        check("rready", rready, m_busy && m_ar_done);
        check("resp_valid", resp_valid, beat ? (2'b01 << m_owner) : 2'b00);
        check("resp_last", resp_last, beat && rlast);
        check("resp_err", resp_err, beat && rlast && (m_err || bad_beat));
        if (beat) begin
            check("resp_data", resp_data, rdata);
        end

        if (arvalid && arready) hs_cnt++;

        if (resetn !== 1'b1) begin
            m_busy = 0; m_ar_done = 0; m_next = 0; m_cnt = 0; m_err = 0;
        end else if (g != 2'b00) begin
            m_busy = 1; m_ar_done = 0; m_owner = g[1]; m_next = !g[1];
            m_addr = g[1] ? req_addr1 : req_addr0;
            m_len  = g[1] ? int'(req_len1) : int'(req_len0);
            m_cnt  = 0; m_err = 0;
        end else if (m_busy && !m_ar_done && arready) begin
            m_ar_done = 1;
        end else if (beat) begin
            if (rlast) begin
                m_busy = 0;
            end else begin
                if (rresp != 2'b00 || m_cnt >= m_len) m_err = 1;
                m_cnt++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req_valid = 2'b00; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    task automatic do_reset();
        quiet();
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
    endtask

    // Request a burst, check its grant pulse and AR address, accept AR at once.
    task automatic start_burst(input bit who, input logic [31:0] addr, input logic [3:0] len,
                               input logic [31:0] exp_araddr);
        if (who) begin req_addr1 = addr; req_len1 = len; req_valid = 2'b10; end
        else     begin req_addr0 = addr; req_len0 = len; req_valid = 2'b01; end
        #2 check("grant_pulse", req_ready, who ? 2'b10 : 2'b01);
        cycle();
        req_valid = 2'b00;
        arready   = 1'b1;
        #2 check("ar_aligned", araddr, exp_araddr);
        cycle();
        arready = 1'b0;
    endtask

    task automatic send_beat(input bit last, input logic [1:0] resp, input bit exp_err,
                             input logic [1:0] exp_rv);
        rvalid = 1'b1; rlast = last; rresp = resp;
        rdata  = {$urandom, $urandom, $urandom, $urandom};
        #2;
        check("beat_valid", resp_valid, exp_rv);
        check("beat_last", resp_last, last);
        check("beat_err", resp_err, exp_err);
        cycle();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
    endtask

    initial begin
        int order[$];
        int r;

        resetn = 1'b0;
        req_addr0 = '0; req_addr1 = '0; req_len0 = '0; req_len1 = '0;
        rdata = '0;
        quiet();
        repeat (3) cycle();
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        resetn = 1'b1;
        cycle();

        // Single request: four beats to requester 0, last on the fourth.
        start_burst(1'b0, 32'h1000_0008, 4'd3, 32'h1000_0000);
        send_beat(1'b0, 2'b00, 1'b0, 2'b01);
        send_beat(1'b0, 2'b00, 1'b0, 2'b01);
        send_beat(1'b0, 2'b00, 1'b0, 2'b01);
        send_beat(1'b1, 2'b00, 1'b0, 2'b01);
        #2 check("single_idle", busy, 1'b0);
        cycle();

        // Contention held across bursts: grant order 0,1,0.
        do_reset();
        req_len0 = 4'd0; req_len1 = 4'd0;
        req_valid = 2'b11; arready = 1'b1; rvalid = 1'b1; rlast = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #2;
            if (req_ready != 2'b00) order.push_back(int'(req_ready[1]));
            cycle();
        end
        quiet();
        check("rr_grants", order.size() >= 3, 1'b1);
        if (order.size() >= 3) begin
            check("rr_first", order[0], 0);
            check("rr_second", order[1], 1);
            check("rr_third", order[2], 0);
        end
        cycle();

        // AR stall: address and length held, exactly one handshake.
        do_reset();
        hs_cnt    = 0;
        req_addr1 = 32'h2000_0037; req_len1 = 4'd1; req_valid = 2'b10;
        cycle();
        req_valid = 2'b00;
        for (int c = 0; c < 5; c++) begin
            #2;
            check("stall_arvalid", arvalid, 1'b1);
            check("stall_araddr", araddr, 32'h2000_0030);
            check("stall_arlen", arlen, 4'd1);
            cycle();
        end
        arready = 1'b1;
        cycle();
        send_beat(1'b0, 2'b00, 1'b0, 2'b10);
        send_beat(1'b1, 2'b00, 1'b0, 2'b10);
        cycle();
        arready = 1'b0;
        check("stall_handshakes", hs_cnt, 1);

        // Slave error on beat 1: reported only with rlast, next burst clean.
        do_reset();
        start_burst(1'b0, 32'h0000_0104, 4'd3, 32'h0000_0100);
        send_beat(1'b0, 2'b00, 1'b0, 2'b01);
        send_beat(1'b0, 2'b10, 1'b0, 2'b01);
        send_beat(1'b0, 2'b00, 1'b0, 2'b01);
        send_beat(1'b1, 2'b00, 1'b1, 2'b01);
        start_burst(1'b1, 32'h0000_0200, 4'd0, 32'h0000_0200);
        send_beat(1'b1, 2'b00, 1'b0, 2'b10);

        // Early rlast on beat 2 of a four-beat burst.
        start_burst(1'b0, 32'h0000_0300, 4'd3, 32'h0000_0300);
        send_beat(1'b0, 2'b00, 1'b0, 2'b01);
        send_beat(1'b0, 2'b00, 1'b0, 2'b01);
        send_beat(1'b1, 2'b00, 1'b1, 2'b01);
        #2 check("early_idle", busy, 1'b0);
        cycle();

        // Reset in DATA after two beats; stray beats afterwards are dropped.
        start_burst(1'b1, 32'h0000_0400, 4'd3, 32'h0000_0400);
        send_beat(1'b0, 2'b00, 1'b0, 2'b10);
        send_beat(1'b0, 2'b00, 1'b0, 2'b10);
        resetn = 1'b0; rvalid = 1'b1;
        cycle();
        resetn = 1'b1; rvalid = 1'b1; rlast = 1'b1;
        #2;
        check("midrst_busy", busy, 1'b0);
        check("midrst_arvalid", arvalid, 1'b0);
        check("midrst_rready", rready, 1'b0);
        check("midrst_resp_valid", resp_valid, 2'b00);
        check("midrst_resp_last", resp_last, 1'b0);
        check("midrst_resp_err", resp_err, 1'b0);
        check("midrst_req_ready", req_ready, 2'b00);
        cycle();
        quiet();
        cycle();

        // Randomized traffic: slave reacts to the model's view of the burst.
        for (int c = 0; c < 4000; c++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_addr0 = $urandom;
            req_addr1 = $urandom;
            req_len0  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            req_len1  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            arready   = ($urandom_range(0, 2) != 0);
            rvalid    = ($urandom_range(0, 3) != 0);
            r         = $urandom_range(0, 19);
            rlast     = (m_cnt == m_len) ? (r != 0) : (r == 0);
            rresp     = (r == 1) ? 2'b10 : ((r == 2) ? 2'b11 : 2'b00);
            rdata     = {$urandom, $urandom, $urandom, $urandom};
            resetn    = ($urandom_range(0, 299) != 0);
            cycle();
        end
        resetn = 1'b1;
        quiet();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI read address width.
REQ-002 SHALL have parameter DATA_W, default 128, AXI read data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port resetn, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 2, per-requester burst request (bit0 = requester 0).
REQ-006 SHALL have port req_ready, output, 2, per-requester request accept.
REQ-007 SHALL have ports req_addr0 and req_addr1, input, ADDR_W, burst start byte address.
REQ-008 SHALL have ports req_len0 and req_len1, input, 4, beats minus one (AXI arlen encoding).
REQ-009 SHALL have the AR channel: araddr (out, ADDR_W), arburst (out, 2), arlen (out, 4), arsize (out, 3), arvalid (out, 1), arready (in, 1).
REQ-010 SHALL have the R channel: rdata (in, DATA_W), rvalid (in, 1), rlast (in, 1), rresp (in, 2), rready (out, 1).
REQ-011 SHALL have port resp_data, output, DATA_W, forwarded beat data.
REQ-012 SHALL have port resp_valid, output, 2, one-hot beat strobe to the owning requester.
REQ-013 SHALL have port resp_last, output, 1, final beat of the burst.
REQ-014 SHALL have port resp_err, output, 1, burst error, valid with resp_last.
REQ-015 SHALL have port busy, output, 1, high whenever state != IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE, with one outstanding burst maximum.
REQ-017 IDLE: if any req_valid, SHALL grant one, pulse its req_ready for exactly 1 cycle, latch addr/len/owner, and enter ADDR next cycle.
REQ-018 Arbitration SHALL be round-robin: on contention the requester not granted last wins; after reset requester 0 has priority.
REQ-019 ADDR: arvalid=1 and araddr/arlen SHALL be held stable until arready; the handshake cycle SHALL transition to DATA.
REQ-020 araddr SHALL equal the latched address with bits [3:0] forced to 0 (16-byte aligned); arburst=2'b01 (INCR); arsize=3'b100 (16 bytes) constant.
REQ-021 DATA: rready=1; rready=0 in all other states.
REQ-022 Each rvalid beat in DATA SHALL be forwarded combinationally: resp_data=rdata, resp_valid=one-hot owner, resp_last=rlast; zero latency.
REQ-023 A 4-bit beat counter SHALL count accepted beats, starting at 0.
REQ-024 The error flag SHALL be set by any beat with rresp!=2'b00, or by rlast asserted while counter != latched len.
REQ-025 resp_err SHALL equal (error flag OR current-beat error) on the rlast beat, and 0 otherwise.
REQ-026 An rlast beat SHALL end the burst: return to IDLE, clear the counter and error flag.
REQ-027 If counter reaches len with no rlast, further beats SHALL still be forwarded and the error flag set; only rlast ends the burst.
REQ-028 rvalid outside DATA SHALL be ignored: no resp_valid.
REQ-029 A new grant SHALL NOT occur in the same cycle as the rlast beat; the earliest next arvalid is 2 cycles after rlast.
REQ-030 req_valid deasserted after grant SHALL NOT cancel the burst.

Reset
REQ-031 resetn=0 at a clock edge SHALL force IDLE, with arvalid=0, rready=0, req_ready=0, resp_valid=0, resp_last=0, resp_err=0, busy=0, counter=0, error flag=0, RR pointer=requester 0.
REQ-032 Reset mid-burst SHALL abandon the burst without draining; beats arriving after reset are dropped per REQ-028.

Structure
REQ-033 A shared package SHALL hold the AXI constants BURST_INCR=2'b01 and SIZE_16B=3'b100, RESP_OKAY=2'b00, and the FSM state enum.
REQ-034 The round-robin grant logic SHALL be a sub-module rr_arbiter2 (inputs req[1:0], last_grant; output grant[1:0]).

Verification
REQ-035 Single request: req_valid=01, addr0=0x1000_0008, len0=3 -> one req_ready pulse, araddr=0x1000_0000, arlen=3, 4 beats to requester 0, resp_last on 4th, resp_err=0.
REQ-036 Contention: req_valid=11 held across 3 bursts -> grant order 0,1,0.
REQ-037 arready stalled 5 cycles -> araddr/arlen stable and arvalid=1 throughout, with exactly one AR handshake.
REQ-038 Error: rresp=2'b10 on beat 1 of a 4-beat burst -> resp_err=1 only on the rlast beat, and the next burst reports resp_err=0.
REQ-039 Early rlast on beat 2 with len=3 -> resp_err=1, return to IDLE, busy=0 the next cycle.
REQ-040 resetn=0 in DATA after 2 beats -> all outputs at reset values next cycle, and stray rvalid produces no resp_valid.
